// File: rtl/mul_pkg.sv
// Shared types and defaults for the mul shift-add multiplier.
package mul_pkg;

    localparam int MUL_A_W = 4;
    localparam int MUL_B_W = 4;
    localparam int MUL_Y_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Counter must hold 0..B_W.
    function automatic int cnt_width(input int b_w);
        return $clog2(b_w + 1);
    endfunction

endpackage

// File: rtl/mul_intf.sv
// Signal bundle for connecting mul to its producers and consumers.
interface mul_intf
    import mul_pkg::*;
#(
    parameter int A_W = MUL_A_W,
    parameter int B_W = MUL_B_W,
    parameter int Y_W = MUL_Y_W
);
    logic           clk;
    logic           rst_n;
    logic           start;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           busy;
    logic           done;
    logic [Y_W-1:0] y;

    modport dut (input clk, rst_n, start, a, b, output busy, done, y);
    modport host (input clk, rst_n, busy, done, y, output start, a, b);
endinterface

// File: rtl/mul_ctrl.sv
// FSM and bit counter for mul: sequences B_W step cycles per accepted start.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int B_W   = MUL_B_W,
    parameter int CNT_W = cnt_width(MUL_B_W)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_load,
    output logic             o_step,
    output logic             o_last,
    output logic [CNT_W-1:0] o_cnt
);

    mul_state_e       r_state;
    mul_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_state == CALC) && (r_cnt == CNT_W'(B_W - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = CALC;
            CALC:    if (w_last) w_state_next = DONE;
            DONE:    w_state_next = i_start ? CALC : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (o_load) begin
                r_cnt <= '0;
            end else if (o_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_busy = (r_state == CALC);
    assign o_done = (r_state == DONE);
    assign o_load = i_start && (r_state != CALC);
    assign o_step = (r_state == CALC);
    assign o_last = w_last;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/mul.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
// Define MUL_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module mul
    import mul_pkg::*;
#(
    parameter int A_W = MUL_A_W,
    parameter int B_W = MUL_B_W,
    parameter int Y_W = MUL_Y_W
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [A_W-1:0] i_a,
    input  logic [B_W-1:0] i_b,
    output logic           o_busy,
    output logic           o_done,
    output logic [Y_W-1:0] o_y
);

    localparam int CNT_W = cnt_width(B_W);

    if (Y_W < A_W + B_W) begin : g_width_check
        $error("mul: Y_W must be >= A_W + B_W");
    end

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt;

    logic [A_W-1:0]   r_a;
    logic [B_W-1:0]   r_b;
    logic [Y_W-1:0]   r_acc;
    logic [Y_W-1:0]   r_y;

    logic [A_W-1:0]   w_a_mag;
    logic [B_W-1:0]   w_b_mag;
    logic [Y_W-1:0]   w_addend;
    logic [Y_W-1:0]   w_acc_next;
    logic [Y_W-1:0]   w_y_load;

    mul_ctrl #(
        .B_W   (B_W),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_load  (w_load),
        .o_step  (w_step),
        .o_last  (w_last),
        .o_cnt   (w_cnt)
    );

`ifdef MUL_SIGNED_EN
    logic r_neg;
    logic w_neg;

    // Magnitude of the most-negative value wraps to itself, which is correct as unsigned.
    assign w_a_mag  = i_a[A_W-1] ? A_W'(~i_a + 1'b1) : i_a;
    assign w_b_mag  = i_b[B_W-1] ? B_W'(~i_b + 1'b1) : i_b;
    assign w_neg    = i_a[A_W-1] ^ i_b[B_W-1];
    assign w_y_load = r_neg ? Y_W'(~w_acc_next + 1'b1) : w_acc_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_neg <= 1'b0;
        end else if (w_load) begin
            r_neg <= w_neg;
        end
    end
`else
    assign w_a_mag  = i_a;
    assign w_b_mag  = i_b;
    assign w_y_load = w_acc_next;
`endif

    assign w_addend   = r_b[0] ? (Y_W'(r_a) << w_cnt) : '0;
    assign w_acc_next = r_acc + w_addend;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_y   <= '0;
        end else if (w_load) begin
            r_a   <= w_a_mag;
            r_b   <= w_b_mag;
            r_acc <= '0;
        end else if (w_step) begin
            r_acc <= w_acc_next;
            r_b   <= r_b >> 1;
            if (w_last) begin
                r_y <= w_y_load;
            end
        end
    end

    assign o_y = r_y;

endmodule

// File: tb/tb_mul.sv
// Directed self-checking bench for mul; signed cases run when MUL_SIGNED_EN is defined.
module tb_mul;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] y;

    int total = 0;
    int bad   = 0;

    mul #(
        .A_W (4),
        .B_W (4),
        .Y_W (16)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== 16'h0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b y=%h, want 0 0 0000", busy, done, y);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Issues start at a negedge; leaves the caller observing CALC cycle 1.
    task automatic issue(input logic [3:0] ta, input logic [3:0] tb);
        start = 1'b1;
        a     = ta;
        b     = tb;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_basic();
        issue(4'd3, 4'd5);
        for (int c = 1; c <= 4; c++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL basic_calc%0d: busy=%b done=%b, want 1 0", c, busy, done);
            end
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || y !== 16'h000F) begin
            bad++;
            $display("FAIL basic_done: done=%b busy=%b y=%h, want 1 0 000f", done, busy, y);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || y !== 16'h000F) begin
            bad++;
            $display("FAIL basic_hold: done=%b busy=%b y=%h, want 0 0 000f", done, busy, y);
        end
    endtask

    task automatic test_max_and_zero();
        logic [15:0] exp_max;
`ifdef MUL_SIGNED_EN
        exp_max = 16'h0001;
`else
        exp_max = 16'h00E1;
`endif
        issue(4'd15, 4'd15);
        repeat (4) @(negedge clk);
        total++;
        if (done !== 1'b1 || y !== exp_max) begin
            bad++;
            $display("FAIL max: done=%b y=%h, want 1 %h", done, y, exp_max);
        end
        @(negedge clk);
        issue(4'd0, 4'd9);
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || y !== exp_max) begin
            bad++;
            $display("FAIL zero_early: done=%b busy=%b y=%h, want 0 1 %h", done, busy, y, exp_max);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || y !== 16'h0000) begin
            bad++;
            $display("FAIL zero: done=%b y=%h, want 1 0000", done, y);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        issue(4'd7, 4'd6);
        @(negedge clk);
        start = 1'b1;
        a     = 4'd2;
        b     = 4'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL ignore_calc: busy=%b done=%b, want 1 0", busy, done);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || y !== 16'd42) begin
            bad++;
            $display("FAIL ignore_done: done=%b y=%0d, want 1 42", done, y);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ignore_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        a     = 4'd4;
        b     = 4'd3;
        @(negedge clk);
        a = 4'd5;
        b = 4'd5;
        repeat (4) @(negedge clk);
        total++;
        if (done !== 1'b1 || y !== 16'd12) begin
            bad++;
            $display("FAIL b2b_first: done=%b y=%0d, want 1 12", done, y);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || y !== 16'd12) begin
            bad++;
            $display("FAIL b2b_noidle: busy=%b done=%b y=%0d, want 1 0 12", busy, done, y);
        end
        repeat (4) @(negedge clk);
        total++;
        if (done !== 1'b1 || y !== 16'd25) begin
            bad++;
            $display("FAIL b2b_second: done=%b y=%0d, want 1 25", done, y);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int pulses;
        issue(4'd9, 4'd9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== 16'h0) begin
            bad++;
            $display("FAIL abort: busy=%b done=%b y=%h, want 0 0 0000", busy, done, y);
        end
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL abort_nodone: done pulses=%0d, want 0", pulses);
        end
        issue(4'd2, 4'd3);
        repeat (4) @(negedge clk);
        total++;
        if (done !== 1'b1 || y !== 16'd6) begin
            bad++;
            $display("FAIL after_abort: done=%b y=%0d, want 1 6", done, y);
        end
        @(negedge clk);
    endtask

`ifdef MUL_SIGNED_EN
    task automatic test_signed();
        logic [3:0]  va [3];
        logic [3:0]  vb [3];
        logic [15:0] ve [3];
        va = '{4'h8, 4'hF, 4'h8};
        vb = '{4'h7, 4'hF, 4'h8};
        ve = '{16'hFFC8, 16'h0001, 16'h0040};
        for (int i = 0; i < 3; i++) begin
            issue(va[i], vb[i]);
            repeat (4) @(negedge clk);
            total++;
            if (done !== 1'b1 || y !== ve[i]) begin
                bad++;
                $display("FAIL signed%0d: done=%b y=%h, want 1 %h", i, done, y, ve[i]);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_max_and_zero();
        test_ignore_start();
        test_back_to_back();
        test_abort();
`ifdef MUL_SIGNED_EN
        test_signed();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
